// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared types and constants for the load/store unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam int         LANE_W   = 2;
    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'h1;

endpackage

`default_nettype wire

// File: rtl/lsu_byte_lane.sv
// ============================================================================
// lsu_byte_lane : byte-enable, store replication and load byte extraction
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  byte_i,
    input  logic [LANE_W-1:0]     lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (byte_i) begin
            be_o    = BE_BYTE0 << lane_i;
            // Bus slaves pick the lane from MemBe, so every lane carries the byte.
            wdata_o = {(DATA_WIDTH/8){wdata_i[7:0]}};
            rdata_o = {{(DATA_WIDTH-8){1'b0}}, rdata_i[{lane_i, 3'b000} +: 8]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// lsu : single-outstanding load/store unit on a req/ack data bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Valid,
    output logic                  Ready,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  ByteOp,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemBe,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Done,
    output logic                  Err,
    output logic                  Stall
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q,    we_d;
    logic                  byte_q,  byte_d;
    logic                  err_q,   err_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic                  w_illegal;
    logic                  w_in_req;
    logic                  w_in_resp;
    logic [3:0]            w_lane_be;
    logic [DATA_WIDTH-1:0] w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_lane_rdata;

    lsu_byte_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_lane (
        .byte_i  (byte_q),
        .lane_i  (addr_q[LANE_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_i (MemRData),
        .be_o    (w_lane_be),
        .wdata_o (w_lane_wdata),
        .rdata_o (w_lane_rdata)
    );

    assign w_illegal = (MemRead && MemWrite) ||
                       (!ByteOp && (ALUResult[LANE_W-1:0] != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Valid && (MemRead || MemWrite)) begin
                    addr_d  = ALUResult;
                    wdata_d = WriteData;
                    we_d    = MemWrite;
                    byte_d  = ByteOp;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = w_illegal;
                    state_d = w_illegal ? RESP : REQ;
                end
            end
            REQ: begin
                // A late ack on the final wait cycle still completes the access.
                if (MemAck) begin
                    if (!we_q) begin
                        rdata_d = w_lane_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_in_req  = (state_q == REQ);
    assign w_in_resp = (state_q == RESP);

    // Bus outputs are quiet outside REQ so nothing leaks while idle or after reset.
    assign MemReq   = w_in_req;
    assign MemWe    = w_in_req & we_q;
    assign MemAddr  = w_in_req ? {addr_q[DATA_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign MemWData = w_in_req ? w_lane_wdata : '0;
    assign MemBe    = w_in_req ? w_lane_be : 4'h0;

    assign Done     = w_in_resp;
    assign Err      = w_in_resp & err_q;
    assign ReadData = w_in_resp ? rdata_q : '0;
    assign Ready    = (state_q == IDLE);
    assign Stall    = ~Ready;

endmodule

`default_nettype wire
